// File: rtl/mem_store_monitor.sv
// mem_store_monitor: logs processor stores into a FIFO and classifies the run as PASS/FAIL.
// Latency: a store sampled at edge N is visible on out_* (if FIFO was empty) and in counters/flags after edge N.
// Backpressure: out_valid/out_ready drain; a store into a full FIFO with no pop is dropped and counted.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   memwrite/dataadr/writedata  - store strobe, byte address and data from the processor
//   out_valid/out_ready         - log head handshake; out_addr/out_data/out_seq carry the head entry
//   store_count/drop_count      - saturating counts of accepted and dropped stores
//   overflow                    - sticky, set on the first drop
//   done/pass/fail/bad_addr     - run classification and the address that caused FAIL
module mem_store_monitor #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] DONE_ADDR = 32'd84,
  parameter logic [31:0] DONE_DATA = 32'd7,
  parameter logic [31:0] WIN_LO    = 32'd0,
  parameter logic [31:0] WIN_HI    = 32'd252
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [15:0] out_seq,
  output logic [15:0] store_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] bad_addr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic [31:0] r_mem_addr [DEPTH];
  logic [31:0] r_mem_data [DEPTH];
  logic [15:0] r_mem_seq  [DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [15:0] r_seq;
  logic [15:0] r_store_count;
  logic [15:0] r_drop_count;
  logic        r_overflow;
  logic [31:0] r_bad_addr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;
  logic w_push;
  logic w_drop;
  logic w_is_done;
  logic w_misalign;
  logic w_in_win;
  logic w_to_fail;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;

  assign w_accept   = memwrite && (r_state == S_RUN);
  assign w_is_done  = (dataadr == DONE_ADDR) && (writedata == DONE_DATA);
  assign w_misalign = (dataadr[1:0] != 2'b00);
  // Single unsigned compare: addresses below WIN_LO wrap to huge offsets.
  assign w_in_win   = (dataadr - WIN_LO) <= (WIN_HI - WIN_LO);
  assign w_to_fail  = w_accept && !w_is_done && (w_misalign || !w_in_win);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push = w_accept && (!w_full || w_pop);
  assign w_drop = w_accept && w_full && !w_pop;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    if (w_accept) begin
      if (w_is_done)      w_next_state = S_PASS;
      else if (w_to_fail) w_next_state = S_FAIL;
    end
  end

  // FSM: outputs
  always_comb begin
    pass = (r_state == S_PASS);
    fail = (r_state == S_FAIL);
    done = pass || fail;
  end

  // Log storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_addr[r_wptr[AW-1:0]] <= dataadr;
      r_mem_data[r_wptr[AW-1:0]] <= writedata;
      r_mem_seq[r_wptr[AW-1:0]]  <= r_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_seq         <= '0;
      r_store_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_bad_addr    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_accept) begin
        // seq keeps advancing on drops so gaps in out_seq expose them.
        r_seq <= r_seq + 16'd1;
        if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_to_fail) r_bad_addr <= dataadr;
    end
  end

  assign out_valid   = !w_empty;
  assign out_addr    = w_empty ? 32'd0 : r_mem_addr[r_rptr[AW-1:0]];
  assign out_data    = w_empty ? 32'd0 : r_mem_data[r_rptr[AW-1:0]];
  assign out_seq     = w_empty ? 16'd0 : r_mem_seq[r_rptr[AW-1:0]];
  assign store_count = r_store_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;
  assign bad_addr    = r_bad_addr;

endmodule

// File: tb/tb_mem_store_monitor.sv
module tb_mem_store_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] out_seq;
  logic [15:0] store_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic [31:0] bad_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_store_monitor dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_seq(out_seq),
    .store_count(store_count), .drop_count(drop_count), .overflow(overflow),
    .done(done), .pass(pass), .fail(fail), .bad_addr(bad_addr)
  );

  // Reference model: a plain queue of logged entries plus run verdict.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] s;
  } ent_t;

  ent_t        mq[$];
  int          m_verdict;   // 0 running, 1 passed, 2 failed
  logic [15:0] m_seq;
  logic [15:0] m_store;
  logic [15:0] m_drop;
  logic        m_ovf;
  logic [31:0] m_bad;

  // Drive one clock of inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic rst);
    ent_t e;
    memwrite = mw; dataadr = a; writedata = d; out_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_verdict = 0; m_seq = '0; m_store = '0; m_drop = '0; m_ovf = 1'b0; m_bad = '0;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (mw && m_verdict == 0) begin
        if (m_store != 16'hFFFF) m_store = m_store + 16'd1;
        if (mq.size() < 16) begin
          e.a = a; e.d = d; e.s = m_seq;
          mq.push_back(e);
        end else begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          m_ovf = 1'b1;
        end
        m_seq = m_seq + 16'd1;
        if (a == 32'd84 && d == 32'd7) m_verdict = 1;
        else if (a[1:0] != 2'b00 || a > 32'd252) begin
          m_verdict = 2; m_bad = a;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'd8, 32'd1, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    total++; if (store_count !== 16'd0) begin bad++; $display("FAIL rst_store got=%0d want=0", store_count); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_count); end
    total++; if ({overflow, done, pass, fail} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {overflow, done, pass, fail}); end
    total++; if (bad_addr !== 32'd0 || out_addr !== 32'd0 || out_data !== 32'd0 || out_seq !== 16'd0) begin
      bad++; $display("FAIL rst_data got=%0d/%0d/%0d/%0d want=0", bad_addr, out_addr, out_data, out_seq);
    end
  endtask

  task automatic test_pass();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 32'd80, 32'd3, 1'b1, 1'b0);
    total++; if ({out_valid, out_addr, out_data, out_seq} !== {1'b1, 32'd80, 32'd3, 16'd0}) begin
      bad++; $display("FAIL pass_e0 got=%0b,%0d,%0d,%0d want=1,80,3,0", out_valid, out_addr, out_data, out_seq);
    end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL pass_early got=%0b want=0", pass); end
    step(1'b1, 32'd80, 32'd5, 1'b1, 1'b0);
    total++; if ({out_valid, out_addr, out_data, out_seq} !== {1'b1, 32'd80, 32'd5, 16'd1}) begin
      bad++; $display("FAIL pass_e1 got=%0b,%0d,%0d,%0d want=1,80,5,1", out_valid, out_addr, out_data, out_seq);
    end
    step(1'b1, 32'd84, 32'd7, 1'b1, 1'b0);
    total++; if ({out_valid, out_addr, out_data, out_seq} !== {1'b1, 32'd84, 32'd7, 16'd2}) begin
      bad++; $display("FAIL pass_e2 got=%0b,%0d,%0d,%0d want=1,84,7,2", out_valid, out_addr, out_data, out_seq);
    end
    total++; if ({pass, fail, done} !== 3'b101) begin bad++; $display("FAIL pass_flags got=%b want=101", {pass, fail, done}); end
    total++; if (store_count !== 16'd3 || drop_count !== 16'd0) begin
      bad++; $display("FAIL pass_counts got=%0d,%0d want=3,0", store_count, drop_count);
    end
    step(1'b1, 32'd4, 32'd9, 1'b1, 1'b0);
    total++; if (store_count !== 16'd3 || out_valid !== 1'b0) begin
      bad++; $display("FAIL pass_ignore got=%0d,%0b want=3,0", store_count, out_valid);
    end
  endtask

  task automatic test_fail_window();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 32'd84, 32'd6, 1'b0, 1'b0);
    total++; if ({pass, fail, done} !== 3'b000) begin bad++; $display("FAIL win_run got=%b want=000", {pass, fail, done}); end
    step(1'b1, 32'd300, 32'd1, 1'b0, 1'b0);
    total++; if ({pass, fail, done} !== 3'b011 || bad_addr !== 32'd300) begin
      bad++; $display("FAIL win_fail got=%b,%0d want=011,300", {pass, fail, done}, bad_addr);
    end
    step(1'b1, 32'd84, 32'd7, 1'b0, 1'b0);
    total++; if (store_count !== 16'd2 || pass !== 1'b0 || bad_addr !== 32'd300) begin
      bad++; $display("FAIL win_ignore got=%0d,%0b,%0d want=2,0,300", store_count, pass, bad_addr);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 32'd82, 32'd1, 1'b0, 1'b0);
    total++; if (fail !== 1'b1 || pass !== 1'b0 || bad_addr !== 32'd82) begin
      bad++; $display("FAIL misalign got=%0b,%0b,%0d want=1,0,82", fail, pass, bad_addr);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 32'(4 * i), 32'(i + 100), 1'b0, 1'b0);
    total++; if (drop_count !== 16'd4 || overflow !== 1'b1 || store_count !== 16'd20) begin
      bad++; $display("FAIL ovf_counts got=%0d,%0b,%0d want=4,1,20", drop_count, overflow, store_count);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_addr !== 32'(4 * i) || out_data !== 32'(i + 100)) begin
        bad++; $display("FAIL ovf_drain%0d got=%0b,%0d,%0d,%0d want=1,%0d,%0d,%0d", i, out_valid, out_seq, out_addr, out_data, i, 4 * i, i + 100);
      end
      step(1'b0, 0, 0, 1'b1, 1'b0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0, 1'b0);
    total++; if (drop_count !== 16'd0 || out_seq !== 16'd0) begin
      bad++; $display("FAIL full_fill got=%0d,%0d want=0,0", drop_count, out_seq);
    end
    step(1'b1, 32'd64, 32'd99, 1'b1, 1'b0);
    total++; if (drop_count !== 16'd0 || out_seq !== 16'd1 || store_count !== 16'd17) begin
      bad++; $display("FAIL full_pushpop got=%0d,%0d,%0d want=0,1,17", drop_count, out_seq, store_count);
    end
    // FIFO still holds 16, so one more store without a pop must drop.
    step(1'b1, 32'd68, 32'd5, 1'b0, 1'b0);
    total++; if (drop_count !== 16'd1 || overflow !== 1'b1) begin
      bad++; $display("FAIL full_still got=%0d,%0b want=1,1", drop_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(8 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'd300, 32'd1, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || store_count !== 16'd0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL midrst got=%0b,%0d,%0d want=0,0,0", out_valid, store_count, drop_count);
    end
    total++; if ({done, fail, overflow} !== 3'b000 || bad_addr !== 32'd0) begin
      bad++; $display("FAIL midrst_flags got=%b,%0d want=000,0", {done, fail, overflow}, bad_addr);
    end
    step(1'b1, 32'd84, 32'd7, 1'b0, 1'b0);
    total++; if (pass !== 1'b1 || out_seq !== 16'd0 || store_count !== 16'd1) begin
      bad++; $display("FAIL midrst_run got=%0b,%0d,%0d want=1,0,1", pass, out_seq, store_count);
    end
  endtask

  task automatic test_random();
    logic        mw, rdy, rst;
    logic [31:0] a, d;
    int          r;
    logic [31:0] ea, ed;
    logic [15:0] es;
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom_range(0, 99));
      mw = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (r < 2)      a = 32'($urandom_range(0, 63) * 4 + 1);
      else if (r < 4) a = 32'($urandom_range(64, 500) * 4);
      else if (r < 6) begin a = 32'd84; d = 32'd7; end
      else            a = 32'($urandom_range(0, 63) * 4);
      rst = (m_verdict != 0 && $urandom_range(0, 9) == 0) || ($urandom_range(0, 199) == 0);
      step(mw, a, d, rdy, rst);
      ea = (mq.size() > 0) ? mq[0].a : 32'd0;
      ed = (mq.size() > 0) ? mq[0].d : 32'd0;
      es = (mq.size() > 0) ? mq[0].s : 16'd0;
      total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd%0d valid got=%0b want=%0b", c, out_valid, mq.size() > 0); end
      total++; if (out_addr !== ea || out_data !== ed || out_seq !== es) begin
        bad++; $display("FAIL rnd%0d head got=%0d,%0d,%0d want=%0d,%0d,%0d", c, out_addr, out_data, out_seq, ea, ed, es);
      end
      total++; if (store_count !== m_store || drop_count !== m_drop || overflow !== m_ovf) begin
        bad++; $display("FAIL rnd%0d counts got=%0d,%0d,%0b want=%0d,%0d,%0b", c, store_count, drop_count, overflow, m_store, m_drop, m_ovf);
      end
      total++; if (pass !== (m_verdict == 1) || fail !== (m_verdict == 2) || done !== (m_verdict != 0)) begin
        bad++; $display("FAIL rnd%0d verdict got=%0b%0b%0b want=%0d", c, pass, fail, done, m_verdict);
      end
      total++; if (bad_addr !== m_bad) begin bad++; $display("FAIL rnd%0d bad_addr got=%0d want=%0d", c, bad_addr, m_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_window();
    test_misalign();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
